reveal_ctrl: RTL and testbench

REVEAL_CTRL -- requirements
Module: reveal_ctrl

---
 rtl/reveal_pkg.sv | 48 ++++
 rtl/reveal_fifo.sv | 52 +++++
 rtl/reveal_ctrl.sv | 137 +++++++++++++
 tb/tb_reveal_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reveal_pkg.sv
// Shared map geometry, cell codes, FSM encoding and neighbour table for reveal_ctrl.
// The NBR state only exists when REVEAL_FLOOD_EN is defined.
package reveal_pkg;

  localparam int MAP_WIDTH       = 8;
  localparam int MAP_HEIGHT      = 8;
  localparam int MAP_CELL_LENGTH = 4;
  localparam int MAP_CELLS       = MAP_WIDTH * MAP_HEIGHT;
  localparam int ADDR_W          = 6;
  localparam int FIFO_DEPTH      = 64;

  localparam logic [MAP_CELL_LENGTH-1:0] CELL_MINE = 4'd9;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_POP  = 3'd1,
    S_WAIT = 3'd2,
    S_EVAL = 3'd3,
`ifdef REVEAL_FLOOD_EN
    S_NBR  = 3'd4,
`endif
    S_DONE = 3'd5
  } state_e;

  // Two's-complement 4-bit offsets so x+dx lands in -1..8 and bit 3 flags off-map.
  typedef struct packed {
    logic [3:0] dx;
    logic [3:0] dy;
  } ofs_t;

  function automatic ofs_t nbr_ofs(input logic [2:0] k);
    ofs_t o;
    unique case (k)
      3'd0: o = '{dx: 4'hF, dy: 4'hF};
      3'd1: o = '{dx: 4'h0, dy: 4'hF};
      3'd2: o = '{dx: 4'h1, dy: 4'hF};
      3'd3: o = '{dx: 4'hF, dy: 4'h0};
      3'd4: o = '{dx: 4'h1, dy: 4'h0};
      3'd5: o = '{dx: 4'hF, dy: 4'h1};
      3'd6: o = '{dx: 4'h0, dy: 4'h1};
      3'd7: o = '{dx: 4'h1, dy: 4'h1};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/reveal_fifo.sv
// Cell-address FIFO for reveal_ctrl: synchronous push/pop/clear,
// first-word-fall-through read, empty/full flags.
module reveal_fifo #(
  parameter int DEPTH = 64,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = count == '0;
  assign full    = count == (PW+1)'(DEPTH);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;

endmodule

// File: rtl/reveal_ctrl.sv
// Minesweeper reveal controller: single-cell reveal, or 8-way flood fill
// from zero cells when REVEAL_FLOOD_EN is defined.
module reveal_ctrl
  import reveal_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_i,
  input  logic                       start_i,
  input  logic [2:0]                 x_i,
  input  logic [2:0]                 y_i,
  output logic [ADDR_W-1:0]          rd_addr_o,
  input  logic [MAP_CELL_LENGTH-1:0] rd_data_i,
  output logic [MAP_CELLS-1:0]       map_shown_o,
  output logic [6:0]                 shown_cnt_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       hit_mine_o
);

  state_e state, nxt;
  addr_t  tgt, push_addr, fifo_dout;
  logic   push, pop, hit_q, is_mine;
  logic   fifo_empty, fifo_full, fifo_clr;

  assign tgt     = {y_i, x_i};
  assign is_mine = rd_data_i == CELL_MINE;
  // A mine ends the reveal early; stale queued cells must not leak into the next one.
  assign fifo_clr = clear_i || (state == S_DONE);

`ifdef REVEAL_FLOOD_EN
  logic [2:0] k;
  ofs_t       ofs;
  logic [3:0] nx, ny;
  addr_t      nbr;
  logic       nbr_ok;

  assign ofs    = nbr_ofs(k);
  assign nx     = {1'b0, rd_addr_o[2:0]} + ofs.dx;
  assign ny     = {1'b0, rd_addr_o[5:3]} + ofs.dy;
  assign nbr    = {ny[2:0], nx[2:0]};
  assign nbr_ok = !nx[3] && !ny[3] && !map_shown_o[nbr];

  always_ff @(posedge clk)
    if (rst || clear_i || state != S_NBR) k <= '0;
    else k <= k + 3'd1;
`endif

  always_comb begin
    nxt       = state;
    push      = 1'b0;
    pop       = 1'b0;
    push_addr = tgt;
    unique case (state)
      S_IDLE: if (start_i) begin
        if (map_shown_o[tgt]) nxt = S_DONE;
        else begin
          push = 1'b1;
          nxt  = S_POP;
        end
      end
      S_POP: if (fifo_empty) nxt = S_DONE;
      else begin
        pop = 1'b1;
        nxt = S_WAIT;
      end
      S_WAIT: nxt = S_EVAL;
      S_EVAL: begin
        if (is_mine) nxt = S_DONE;
`ifdef REVEAL_FLOOD_EN
        else if (rd_data_i == '0) nxt = S_NBR;
`endif
        else nxt = S_POP;
      end
`ifdef REVEAL_FLOOD_EN
      S_NBR: begin
        push      = nbr_ok;
        push_addr = nbr;
        if (k == 3'd7) nxt = S_POP;
      end
`endif
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (clear_i) begin
      nxt  = S_IDLE;
      push = 1'b0;
      pop  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      state       <= S_IDLE;
      map_shown_o <= '0;
      shown_cnt_o <= '0;
      rd_addr_o   <= '0;
      hit_q       <= 1'b0;
    end else begin
      state <= nxt;
      hit_q <= (state == S_EVAL) && is_mine;
      if (pop) rd_addr_o <= fifo_dout;
      if (push) begin
        map_shown_o[push_addr] <= 1'b1;
        shown_cnt_o            <= shown_cnt_o + 7'd1;
      end
    end
  end

  assign busy_o     = state inside {S_POP, S_WAIT, S_EVAL
`ifdef REVEAL_FLOOD_EN
                                    , S_NBR
`endif
                                    };
  assign done_o     = state == S_DONE;
  assign hit_mine_o = done_o && hit_q;

  reveal_fifo #(
    .DEPTH(FIFO_DEPTH),
    .W    (ADDR_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .clear(fifo_clr),
    .push (push),
    .pop  (pop),
    .din  (push_addr),
    .dout (fifo_dout),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst) !(push && fifo_full)
  );

endmodule

// File: tb/tb_reveal_ctrl.sv
// Bench for reveal_ctrl: BFS reference model plus per-cycle compare;
// follows REVEAL_FLOOD_EN so either build can be checked.
module tb_reveal_ctrl;

`ifdef REVEAL_FLOOD_EN
  localparam bit FLOOD = 1'b1;
`else
  localparam bit FLOOD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear_i = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  x_i = '0;
  logic [2:0]  y_i = '0;
  logic [5:0]  rd_addr_o;
  logic [3:0]  rd_data_i;
  logic [63:0] map_shown_o;
  logic [6:0]  shown_cnt_o;
  logic        busy_o, done_o, hit_mine_o;

  reveal_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (clear_i),
    .start_i    (start_i),
    .x_i        (x_i),
    .y_i        (y_i),
    .rd_addr_o  (rd_addr_o),
    .rd_data_i  (rd_data_i),
    .map_shown_o(map_shown_o),
    .shown_cnt_o(shown_cnt_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .hit_mine_o (hit_mine_o)
  );

  initial forever #5 clk = ~clk;

  logic [3:0] map_mem [64];
  always @(posedge clk) rd_data_i <= map_mem[rd_addr_o];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] model_shown = '0;
  logic [63:0] exp_shown = '0;
  bit          exp_hit;
  bit          txn_active = 0;
  bit          chk_en = 0;
  bit          seen_done, seen_hit;
  int          acc_cyc = 0;
  int          exp_done_cyc = -1;
  int          done_at = -1;
  int          ml, dl;
  bit          dh;
  logic        due;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Reference: BFS over the map; latency counts 3 cycles per evaluated
  // cell, 8 more for each zero cell scanned, and 1 for the final empty pop.
  task automatic model_run(input int x, input int y,
                           output int lat, output bit hit);
    int q[$];
    int a, nx, ny;
    lat = 0;
    hit = 0;
    if (model_shown[y*8+x]) return;
    model_shown[y*8+x] = 1'b1;
    q.push_back(y*8+x);
    while (q.size() > 0) begin
      a = q.pop_front();
      lat += 3;
      if (map_mem[a] == 4'd9) begin
        hit = 1;
        return;
      end
      if (FLOOD && map_mem[a] == 4'd0) begin
        lat += 8;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++) begin
            nx = a % 8 + dx;
            ny = a / 8 + dy;
            if ((dx != 0 || dy != 0) && nx >= 0 && nx < 8 &&
                ny >= 0 && ny < 8 && !model_shown[ny*8+nx]) begin
              model_shown[ny*8+nx] = 1'b1;
              q.push_back(ny*8+nx);
            end
          end
      end
    end
    lat += 1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      due = txn_active && (cyc == exp_done_cyc);
      check("done_o", done_o, due);
      check("hit_mine_o", hit_mine_o, due && exp_hit);
      check("busy_o", busy_o,
            txn_active && cyc >= acc_cyc && cyc < exp_done_cyc);
      check("shown_subset", map_shown_o & ~exp_shown, 64'd0);
      if (!txn_active || due) begin
        check("map_shown_o", map_shown_o, exp_shown);
        check("shown_cnt_o", shown_cnt_o, $countones(exp_shown));
      end
      if (txn_active && busy_o && cyc > acc_cyc)
        check("rd_addr_revealed", exp_shown[rd_addr_o], 1'b1);
      if (done_o && !seen_done) begin
        seen_done = 1;
        seen_hit  = hit_mine_o;
        done_at   = cyc;
      end
    end
  end

  task automatic launch(input int x, input int y, output int mlat);
    bit mhit;
    model_run(x, y, mlat, mhit);
    @(posedge clk); #1;
    start_i      = 1'b1;
    x_i          = 3'(x);
    y_i          = 3'(y);
    acc_cyc      = cyc + 1;
    exp_done_cyc = acc_cyc + mlat;
    exp_hit      = mhit;
    exp_shown    = model_shown;
    seen_done    = 0;
    seen_hit     = 0;
    done_at      = -1;
    txn_active   = 1;
  endtask

  task automatic reveal(input int x, input int y, input int poke,
                        output int mlat, output int dlat, output bit dhit);
    launch(x, y, mlat);
    for (int i = 0; i < mlat + 16 && !seen_done; i++) begin
      @(posedge clk); #1;
      start_i = (i == poke);
      x_i     = 3'(x + 1);
      y_i     = 3'(y + 1);
    end
    start_i = 1'b0;
    check("done_seen", seen_done, 1'b1);
    txn_active = 0;
    dlat = done_at - acc_cyc;
    dhit = seen_hit;
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i     = 1'b0;
    model_shown = '0;
    exp_shown   = '0;
    @(negedge clk);
    check("clear_map", map_shown_o, 64'd0);
    check("clear_cnt", shown_cnt_o, 7'd0);
  endtask

  task automatic abort_txn(input bit by_rst, input int at);
    int mlat;
    launch(0, 0, mlat);
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (at - 1) @(posedge clk);
    #1;
    if (by_rst) rst = 1'b1;
    else clear_i = 1'b1;
    @(posedge clk); #1;
    rst         = 1'b0;
    clear_i     = 1'b0;
    model_shown = '0;
    exp_shown   = '0;
    txn_active  = 0;
    @(negedge clk);
    check(by_rst ? "rst_abort_map" : "clr_abort_map", map_shown_o, 64'd0);
    check(by_rst ? "rst_abort_busy" : "clr_abort_busy", busy_o, 1'b0);
    check(by_rst ? "rst_abort_addr" : "clr_abort_cnt",
          by_rst ? 64'(rd_addr_o) : 64'(shown_cnt_o), 64'd0);
    repeat (mlat + 4) @(posedge clk);
    check(by_rst ? "rst_abort_no_done" : "clr_abort_no_done",
          seen_done, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) map_mem[i] = 4'd1;
    map_mem[19] = 4'd2;
    map_mem[9]  = 4'd9;
    map_mem[63] = 4'd0;

    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1;
    @(negedge clk);
    check("rst_rd_addr", rd_addr_o, 6'd0);
    check("rst_cnt", shown_cnt_o, 7'd0);
    check("rst_map", map_shown_o, 64'd0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_hit", hit_mine_o, 1'b0);

    reveal(3, 2, -1, ml, dl, dh);
    check("c32_model_lat", ml, 4);
    check("c32_lat", dl, 4);
    check("c32_map", map_shown_o, 64'h0000_0000_0008_0000);
    check("c32_cnt", shown_cnt_o, 7'd1);
    check("c32_hit", dh, 1'b0);

    reveal(1, 1, -1, ml, dl, dh);
    check("mine_model_lat", ml, 3);
    check("mine_lat", dl, 3);
    check("mine_hit", dh, 1'b1);
    check("mine_map", map_shown_o, 64'h0000_0000_0008_0200);

    reveal(3, 2, -1, ml, dl, dh);
    check("shown_lat", dl, 0);
    check("shown_map", map_shown_o, 64'h0000_0000_0008_0200);

    reveal(4, 4, 1, ml, dl, dh);
    check("busy_start_lat", dl, 4);
    check("busy_start_map", map_shown_o, 64'h0000_0010_0008_0200);

    reveal(7, 7, -1, ml, dl, dh);
    check("corner_model_lat", ml, FLOOD ? 21 : 4);
    check("corner_lat", dl, FLOOD ? 21 : 4);
    check("corner_map", map_shown_o,
          FLOOD ? 64'hC0C0_0010_0008_0200 : 64'h8000_0010_0008_0200);

    do_clear();
    for (int i = 0; i < 64; i++) map_mem[i] = 4'd0;

    // DONE is entered at edge 705 in the flood build, sampled by edge 706.
    reveal(0, 0, -1, ml, dl, dh);
    check("flood_model_lat", ml, FLOOD ? 705 : 4);
    check("flood_lat", dl, FLOOD ? 705 : 4);
    check("flood_map", map_shown_o,
          FLOOD ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h1);
    check("flood_cnt", shown_cnt_o, FLOOD ? 7'd64 : 7'd1);

    do_clear();
    abort_txn(1'b0, FLOOD ? 20 : 2);
    abort_txn(1'b1, FLOOD ? 20 : 2);

    map_mem[45] = 4'd9;
    reveal(5, 5, -1, ml, dl, dh);
    check("post_rst_lat", dl, 3);
    check("post_rst_hit", dh, 1'b1);
    check("post_rst_map", map_shown_o, 64'h0000_2000_0000_0000);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
